// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory AXI-lite read port.
package imem_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CAPT = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  localparam logic [1:0]  RESP_OKAY    = 2'b00;
  localparam logic [1:0]  RESP_SLVERR  = 2'b10;

  localparam logic [31:0] BASE_DEFAULT = 32'h8000_0000;
  localparam logic [31:0] SIZE_DEFAULT = 32'h0800_0000;

  // Doubleword fetches: the low address bits below this are dropped.
  localparam int          ALIGN_LSB    = 3;

endpackage

// File: rtl/imem_axil_rd_if.sv
// AR/R channel bundle of the fetch port, plus the fetch-flush side signal.
interface imem_axil_rd_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);

  logic              ARVALID;
  logic [ADDR_W-1:0] ARADDR;
  logic              ARREADY;
  logic              RVALID;
  logic              RREADY;
  logic [DATA_W-1:0] RDATA;
  logic [1:0]        RRESP;
  logic              flush;

  modport slave (
    input  ARVALID, ARADDR, RREADY, flush,
    output ARREADY, RVALID, RDATA, RRESP
  );

  modport master (
    output ARVALID, ARADDR, RREADY, flush,
    input  ARREADY, RVALID, RDATA, RRESP
  );

endinterface

// File: rtl/imem_axil_rd.sv
// AXI-lite read-only slave returning aligned 64-bit instruction words from a
// synchronous SRAM, with address range check, extra latency and fetch flush.
module imem_axil_rd
  import imem_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 64,
  parameter logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_DEFAULT),
  parameter logic [ADDR_W-1:0] SIZE      = ADDR_W'(SIZE_DEFAULT),
  parameter int                LAT_EXTRA = 0
) (
  input  logic              clk,
  input  logic              rst,
  imem_axil_rd_if.slave     axi,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [3:0] LAT_CNT = 4'(LAT_EXTRA);

  state_t            state_reg;
  logic [3:0]        cnt_reg;
  logic              drop_reg;
  logic              rvalid_reg;
  logic [DATA_W-1:0] rdata_reg;
  logic [1:0]        rresp_reg;

  logic              ar_ready;
  logic              ar_hs;
  logic              in_range;
  logic              drop_now;
  logic [ADDR_W:0]   addr_ext;
  logic [ADDR_W:0]   lo_ext;
  logic [ADDR_W:0]   hi_ext;

  // One extra bit so BASE+SIZE at the top of the map cannot wrap to zero.
  assign addr_ext = {1'b0, axi.ARADDR};
  assign lo_ext   = {1'b0, BASE};
  assign hi_ext   = {1'b0, BASE} + {1'b0, SIZE};
  assign in_range = (addr_ext >= lo_ext) && (addr_ext < hi_ext);

  assign ar_ready = !rst && ((state_reg == S_IDLE) ||
                    ((state_reg == S_RESP) && axi.RREADY && !axi.flush));
  assign ar_hs    = axi.ARVALID && ar_ready;
  assign mem_req  = ar_hs && in_range;
  assign mem_addr = {axi.ARADDR[ADDR_W-1:ALIGN_LSB], {ALIGN_LSB{1'b0}}};
  assign drop_now = drop_reg || axi.flush;

  assign axi.ARREADY = ar_ready;
  assign axi.RVALID  = rvalid_reg;
  assign axi.RDATA   = rdata_reg;
  assign axi.RRESP   = rresp_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= S_IDLE;
      cnt_reg    <= 4'd0;
      drop_reg   <= 1'b0;
      rvalid_reg <= 1'b0;
      rdata_reg  <= '0;
      rresp_reg  <= RESP_OKAY;
    end else begin
      case (state_reg)
        S_IDLE: begin
          drop_reg <= 1'b0;
        end
        S_CAPT: begin
          rdata_reg <= mem_rdata;
          rresp_reg <= RESP_OKAY;
          if (LAT_CNT == 4'd0) begin
            state_reg  <= drop_now ? S_IDLE : S_RESP;
            rvalid_reg <= !drop_now;
            drop_reg   <= 1'b0;
          end else begin
            state_reg <= S_WAIT;
            cnt_reg   <= LAT_CNT;
            drop_reg  <= drop_now;
          end
        end
        S_WAIT: begin
          if (cnt_reg <= 4'd1) begin
            cnt_reg    <= 4'd0;
            drop_reg   <= 1'b0;
            state_reg  <= drop_now ? S_IDLE : S_RESP;
            rvalid_reg <= !drop_now;
          end else begin
            cnt_reg  <= cnt_reg - 4'd1;
            drop_reg <= drop_now;
          end
        end
        S_RESP: begin
          if (axi.flush || axi.RREADY) begin
            state_reg  <= S_IDLE;
            rvalid_reg <= 1'b0;
          end
        end
        default: state_reg <= S_IDLE;
      endcase

      // An accepted address overrides the IDLE / RESP-handshake defaults above.
      if (ar_hs) begin
        if (in_range) begin
          state_reg  <= S_CAPT;
          rvalid_reg <= 1'b0;
        end else begin
          state_reg  <= S_RESP;
          rvalid_reg <= 1'b1;
          rdata_reg  <= '0;
          rresp_reg  <= RESP_SLVERR;
        end
      end
    end
  end

endmodule
